// File: rtl/alu_mc_pkg.sv
// Shared op codes, FSM state encoding and op-class helper for the alu_mc multi-cycle ALU.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLL   = 4'd4,
        OP_SRL   = 4'd5,
        OP_SRA   = 4'd6,
        OP_XOR   = 4'd7,
        OP_MUL   = 4'd8,
        OP_MULHU = 4'd9,
        OP_DIVU  = 4'd10,
        OP_REMU  = 4'd11,
        OP_SLT   = 4'd12,
        OP_SLTU  = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int OP_W = 4;

    // Codes 8..11 form the iterative class; bit 1 selects divide, bit 0 selects high/remainder.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle over WIDTH cycles.
// done and result are combinational during the final iteration so the caller latches them on that edge.
module alu_mc_muldiv
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic             r_active;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_is_hi;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Multiply keeps {acc,lo} as the running product; divide keeps acc as remainder, lo as dividend/quotient.
    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_rem_sh  = {r_acc, r_lo[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_b};
        w_fits    = ~w_diff[WIDTH];
        if (r_is_div) begin
            w_acc_nxt = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            w_lo_nxt  = {r_lo[WIDTH-2:0], w_fits};
        end else begin
            w_acc_nxt = w_mul_sum[WIDTH:1];
            w_lo_nxt  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign done   = r_active && (r_cnt == CW'(WIDTH - 1));
    assign result = r_is_hi ? w_acc_nxt : w_lo_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (r_active) begin
            r_cnt <= done ? '0 : r_cnt + 1'b1;
            if (done)
                r_active <= 1'b0;
        end
    end

    // Datapath registers carry no reset; control above decides when they matter.
    always_ff @(posedge clk) begin
        if (start) begin
            r_acc    <= '0;
            r_lo     <= a;
            r_b      <= b;
            r_is_div <= is_div;
            r_is_hi  <= is_hi;
        end else if (r_active) begin
            r_acc <= w_acc_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle logic/arith ops plus optional
// iterative MUL/MULHU/DIVU/REMU enabled by defining ALU_MC_MULDIV_EN.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    state_e           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic                    w_accept;
    logic [WIDTH-1:0]        w_alu;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic [SHW-1:0]          w_sh;

    assign w_a_s = a;
    assign w_b_s = b;
    assign w_sh  = b[SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (op)
            OP_ADD:  w_alu = a + b;
            OP_SUB:  w_alu = a - b;
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_XOR:  w_alu = a ^ b;
            OP_SLL:  w_alu = a << w_sh;
            OP_SRL:  w_alu = a >> w_sh;
            OP_SRA:  w_alu = w_a_s >>> w_sh;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
            OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
            default: w_alu = '0;
        endcase
    end

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;

`ifdef ALU_MC_MULDIV_EN
    logic             r_busy;
    logic             w_is_md;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_result;

    assign w_is_md = is_muldiv(op);
    assign busy    = r_busy;

    alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_accept && w_is_md),
        .is_div (op[1]),
        .is_hi  (op[0]),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .result (w_md_result)
    );
`else
    assign busy = 1'b0;
`endif

    // A new acceptance is written last so it overrides the handoff from DONE on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
`ifdef ALU_MC_MULDIV_EN
            r_busy      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
`ifdef ALU_MC_MULDIV_EN
                ST_MUL, ST_DIV: begin
                    if (w_md_done) begin
                        r_result    <= w_md_result;
                        r_zero      <= (w_md_result == '0);
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
`endif
                default: ;
            endcase

            if (w_accept) begin
`ifdef ALU_MC_MULDIV_EN
                if (w_is_md) begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b1;
                    r_state     <= op[1] ? ST_DIV : ST_MUL;
                end else begin
                    r_result    <= w_alu;
                    r_zero      <= (w_alu == '0);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
`else
                r_result    <= w_alu;
                r_zero      <= (w_alu == '0);
                r_out_valid <= 1'b1;
                r_state     <= ST_DONE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32), with iterative-op vectors chosen by ALU_MC_MULDIV_EN.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one op with out_ready=1, measure cycles to out_valid, check result and handoff.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int n      = 0;
        int busy_n = 0;
        int rdy_n  = 0;
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        while (!out_valid && n < 200) begin
            busy_n += int'(busy);
            rdy_n  += int'(in_ready);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n + 1), 32'(exp_lat));
        chk({tag, "_result"}, result, exp);
        chk({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
        if (exp_lat > 1) begin
            chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
            chk({tag, "_ready_low"}, 32'(rdy_n), 32'd0);
        end
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_handoff"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        run_op("sub_5_7", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        run_op("or", OP_OR, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1);
        run_op("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
        run_op("sll_36", OP_SLL, 32'h0000_0001, 32'd36, 32'h0000_0010, 1);
        run_op("sra_33", OP_SRA, 32'h8000_0000, 32'd33, 32'hC000_0000, 1);
        run_op("srl_33", OP_SRL, 32'h8000_0000, 32'd33, 32'h4000_0000, 1);
        run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("sltu_big", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("op14", OP_RSV14, 32'd9, 32'd9, 32'd0, 1);
        run_op("op15", OP_RSV15, 32'd9, 32'd9, 32'd0, 1);

`ifdef ALU_MC_MULDIV_EN
        run_op("mul_6_7", OP_MUL, 32'd6, 32'd7, 32'd42, 33);
        run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 33);
        run_op("remu_by0", OP_REMU, 32'd100, 32'd0, 32'd100, 33);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
`else
        run_op("mul_off", OP_MUL, 32'd6, 32'd7, 32'd0, 1);
        run_op("mulhu_off", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_off", OP_DIVU, 32'd100, 32'd7, 32'd0, 1);
        run_op("remu_off", OP_REMU, 32'd100, 32'd7, 32'd0, 1);
`endif

        // Stall the consumer: result held, no acceptance, then handoff and accept together.
        out_ready = 1'b0;
        op = OP_ADD; a = 32'd10; b = 32'd20; in_valid = 1'b1;
        tick();
        a = 32'd1; b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", result, 32'd30);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", result, 32'd2);
        tick();
        chk("b2b_handoff", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of work.
`ifdef ALU_MC_MULDIV_EN
        op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        chk("mid_div_busy", 32'(busy), 32'd1);
`else
        out_ready = 1'b0;
        op = OP_ADD; a = 32'd7; b = 32'd8; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
`endif
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_zero", 32'(zero), 32'd1);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #1 rst = 1'b0;
        run_op("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (power of two, 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0].
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  unit accepts operation this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 op  input  4  operation code.
REQ-009 out_valid  output  1  result held valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero  output  1  result == 0, registered with result.
REQ-013 busy  output  1  iterative operation in progress.

Function
REQ-014 Ops 0-7 SHALL be ADD, SUB, AND, OR, SLL, SRL (logical), SRA (arithmetic), XOR; 12 SLT (signed, 1/0); 13 SLTU; 8 MUL (low WIDTH), 9 MULHU (high WIDTH, unsigned), 10 DIVU, 11 REMU; 14, 15 SHALL yield 0.
REQ-015 Transfer SHALL occur when in_valid && in_ready at a rising edge; output handoff when out_valid && out_ready.
REQ-016 FSM states IDLE, MUL, DIV, DONE; IDLE->DONE for single-cycle ops, IDLE->MUL for 8/9, IDLE->DIV for 10/11, MUL/DIV->DONE after WIDTH iterations, DONE->IDLE on handoff.
REQ-017 Single-cycle ops: out_valid SHALL rise the cycle after acceptance (latency 1).
REQ-018 MUL/MULHU: shift-add, one bit per cycle; out_valid SHALL rise exactly WIDTH+1 cycles after acceptance.
REQ-019 DIVU/REMU: restoring division, one bit per cycle; out_valid SHALL rise exactly WIDTH+1 cycles after acceptance.
REQ-020 Divide by zero SHALL yield quotient all-ones and remainder = a, same latency.
REQ-021 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1 (back-to-back accept on handoff cycle); 0 in MUL/DIV.
REQ-022 result/zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Operands SHALL be captured at acceptance; input changes afterwards SHALL not affect the result.
REQ-024 busy SHALL equal 1 exactly in MUL and DIV.
REQ-025 All arithmetic SHALL wrap modulo 2^WIDTH; no overflow flag.

Reset
REQ-026 Asserting rst SHALL immediately force IDLE, out_valid=0, result=0, zero=1, busy=0, iteration counter=0, regardless of state (mid-iteration work discarded).
REQ-027 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro ALU_MC_MULDIV_EN defined: ops 8-11 behave per REQ-018..020.
REQ-029 Macro undefined: ops 8-11 SHALL complete as single-cycle ops returning 0; MUL/DIV states and datapath SHALL not be synthesised; busy tied 0.

Structure
REQ-030 Package alu_mc_pkg SHALL hold op-code localparams/enum and FSM state enum.
REQ-031 Iterative datapath SHALL be sub-module alu_mc_muldiv (start, is_div, is_hi/is_rem, done, result), instantiated only under ALU_MC_MULDIV_EN.

Verification
REQ-032 WIDTH=32, SUB a=5 b=7, out_ready=1 -> next cycle result=0xFFFFFFFE, zero=0.
REQ-033 SRA a=0x80000000 b=33 -> 0xC0000000 (shift 1); SRL same -> 0x40000000.
REQ-034 MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE exactly 33 cycles after accept, busy high 32 cycles, in_ready low meanwhile.
REQ-035 DIVU a=100 b=0 -> 0xFFFFFFFF; REMU a=100 b=0 -> 100; REMU a=100 b=7 -> 2.
REQ-036 ADD result with out_ready held 0 for 5 cycles -> result stable, in_ready 0; then out_ready=1 with new in_valid -> handoff and accept same cycle.
REQ-037 rst pulsed during 16th DIVU iteration -> out_valid=0, busy=0, result=0 immediately; next ADD 2+3 -> 5 with latency 1.
